// File: rtl/cmp_operand_sequencer_if.sv
// cmp_operand_sequencer_if
//   Bundles every non-clock/reset signal of cmp_operand_sequencer.
//   master : upstream environment. It drives start/ser_in and the comparator
//            results A_gt_B/A_lt_B/A_eq_B.
//   slave  : the sequencer. It drives operand bits A3..A0/B3..B0, busy, done,
//            the registered results gt_q/lt_q/eq_q and err.
//   Optional macro CMP_SEQ_STATS_EN adds the 8-bit gt_cnt/lt_cnt/eq_cnt counters.
interface cmp_operand_sequencer_if;
  logic start;
  logic ser_in;
  logic A_gt_B;
  logic A_lt_B;
  logic A_eq_B;
  logic A3, A2, A1, A0;
  logic B3, B2, B1, B0;
  logic busy;
  logic done;
  logic gt_q;
  logic lt_q;
  logic eq_q;
  logic err;
`ifdef CMP_SEQ_STATS_EN
  logic [7:0] gt_cnt;
  logic [7:0] lt_cnt;
  logic [7:0] eq_cnt;

  modport master (
    output start, ser_in, A_gt_B, A_lt_B, A_eq_B,
    input  A3, A2, A1, A0, B3, B2, B1, B0,
    input  busy, done, gt_q, lt_q, eq_q, err,
    input  gt_cnt, lt_cnt, eq_cnt
  );

  modport slave (
    input  start, ser_in, A_gt_B, A_lt_B, A_eq_B,
    output A3, A2, A1, A0, B3, B2, B1, B0,
    output busy, done, gt_q, lt_q, eq_q, err,
    output gt_cnt, lt_cnt, eq_cnt
  );
`else
  modport master (
    output start, ser_in, A_gt_B, A_lt_B, A_eq_B,
    input  A3, A2, A1, A0, B3, B2, B1, B0,
    input  busy, done, gt_q, lt_q, eq_q, err
  );

  modport slave (
    input  start, ser_in, A_gt_B, A_lt_B, A_eq_B,
    output A3, A2, A1, A0, B3, B2, B1, B0,
    output busy, done, gt_q, lt_q, eq_q, err
  );
`endif
endinterface

// File: rtl/cmp_operand_sequencer.sv
// cmp_operand_sequencer
//   Serial operand loader and result capture stage for a 4-bit magnitude
//   comparator. Eight ser_in bits (A3..A0 then B3..B0) are shifted in one per
//   clock and driven onto the comparator operand pins. Operands are then held
//   for SETTLE_CYCLES clocks. The comparator outputs are registered in CAPTURE,
//   and done pulses for one cycle.
//   Ports:
//     clk  - system clock, rising edge
//     rst  - asynchronous, active-high reset
//     bus  - cmp_operand_sequencer_if.slave:
//            start, ser_in, A_gt_B, A_lt_B and A_eq_B are inputs.
//            A3..A0, B3..B0, busy, done, gt_q, lt_q, eq_q and err are outputs.
//   Parameter SETTLE_CYCLES (0..15, default 1): hold time before capture.
//   Optional macro CMP_SEQ_STATS_EN: adds the saturating 8-bit gt_cnt, lt_cnt
//   and eq_cnt capture counters.
module cmp_operand_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  cmp_operand_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    SETTLE  = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  // Settle counter value on the last SETTLE edge. It is unused when
  // SETTLE_CYCLES is 0.
  localparam logic [3:0] SETTLE_LAST =
    (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q;
  logic [3:0] settle_cnt_q;
  logic [3:0] a_q, b_q;
  logic       done_q;
  logic       gt_q, lt_q, eq_q, err_q;
  logic       one_hot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = LOAD;
      end
      LOAD: begin
        if (bit_cnt_q == 3'd7) begin
          if (SETTLE_CYCLES == 0) state_d = CAPTURE;
          else                    state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) state_d = CAPTURE;
      end
      CAPTURE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Both counters are zero whenever their state is not active. Each LOAD
  // and SETTLE visit therefore starts from 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q    <= '0;
      settle_cnt_q <= '0;
    end else begin
      if (state_q == LOAD) bit_cnt_q <= bit_cnt_q + 3'd1;
      else                 bit_cnt_q <= '0;
      if (state_q == SETTLE) settle_cnt_q <= settle_cnt_q + 4'd1;
      else                   settle_cnt_q <= '0;
    end
  end

  // The MSB is shifted in first. Counter 0..3 maps to A3..A0, and counter
  // 4..7 maps to B3..B0, so the inverted low bits give the register index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (state_q == LOAD) begin
      if (!bit_cnt_q[2]) a_q[~bit_cnt_q[1:0]] <= bus.ser_in;
      else               b_q[~bit_cnt_q[1:0]] <= bus.ser_in;
    end
  end

  always_comb begin
    one_hot = 1'b0;
    case ({bus.A_gt_B, bus.A_lt_B, bus.A_eq_B})
      3'b100, 3'b010, 3'b001: one_hot = 1'b1;
      default:                one_hot = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
      gt_q   <= 1'b0;
      lt_q   <= 1'b0;
      eq_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= (state_q == CAPTURE);
      if (state_q == CAPTURE) begin
        gt_q  <= bus.A_gt_B;
        lt_q  <= bus.A_lt_B;
        eq_q  <= bus.A_eq_B;
        err_q <= ~one_hot;
      end
    end
  end

`ifdef CMP_SEQ_STATS_EN
  logic [7:0] gt_cnt_q, lt_cnt_q, eq_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gt_cnt_q <= '0;
      lt_cnt_q <= '0;
      eq_cnt_q <= '0;
    end else if (state_q == CAPTURE) begin
      if (bus.A_gt_B && (gt_cnt_q != '1)) gt_cnt_q <= gt_cnt_q + 8'd1;
      if (bus.A_lt_B && (lt_cnt_q != '1)) lt_cnt_q <= lt_cnt_q + 8'd1;
      if (bus.A_eq_B && (eq_cnt_q != '1)) eq_cnt_q <= eq_cnt_q + 8'd1;
    end
  end

  assign bus.gt_cnt = gt_cnt_q;
  assign bus.lt_cnt = lt_cnt_q;
  assign bus.eq_cnt = eq_cnt_q;
`endif

  assign bus.A3   = a_q[3];
  assign bus.A2   = a_q[2];
  assign bus.A1   = a_q[1];
  assign bus.A0   = a_q[0];
  assign bus.B3   = b_q[3];
  assign bus.B2   = b_q[2];
  assign bus.B1   = b_q[1];
  assign bus.B0   = b_q[0];
  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.gt_q = gt_q;
  assign bus.lt_q = lt_q;
  assign bus.eq_q = eq_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_cmp_operand_sequencer.sv
// tb_cmp_operand_sequencer
//   Directed, table-driven bench for cmp_operand_sequencer.
//   dut1 uses SETTLE_CYCLES=1 and dut0 uses SETTLE_CYCLES=0. Both share the
//   start/ser_in stimulus. Each one has its own behavioural 4-bit comparator,
//   which can be overridden to inject non-one-hot results.
//   Counter checks run when CMP_SEQ_STATS_EN is defined.
module tb_cmp_operand_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       tb_start;
  logic       tb_ser;
  logic       force_en;
  logic [2:0] force_val;  // {gt, lt, eq}
  logic       sel;        // 1: observe dut1, 0: observe dut0

  cmp_operand_sequencer_if bus1 ();
  cmp_operand_sequencer_if bus0 ();

  assign bus1.start  = tb_start;
  assign bus1.ser_in = tb_ser;
  assign bus0.start  = tb_start;
  assign bus0.ser_in = tb_ser;

  assign bus1.A_gt_B = force_en ? force_val[2] :
    ({bus1.A3, bus1.A2, bus1.A1, bus1.A0} >  {bus1.B3, bus1.B2, bus1.B1, bus1.B0});
  assign bus1.A_lt_B = force_en ? force_val[1] :
    ({bus1.A3, bus1.A2, bus1.A1, bus1.A0} <  {bus1.B3, bus1.B2, bus1.B1, bus1.B0});
  assign bus1.A_eq_B = force_en ? force_val[0] :
    ({bus1.A3, bus1.A2, bus1.A1, bus1.A0} == {bus1.B3, bus1.B2, bus1.B1, bus1.B0});
  assign bus0.A_gt_B = force_en ? force_val[2] :
    ({bus0.A3, bus0.A2, bus0.A1, bus0.A0} >  {bus0.B3, bus0.B2, bus0.B1, bus0.B0});
  assign bus0.A_lt_B = force_en ? force_val[1] :
    ({bus0.A3, bus0.A2, bus0.A1, bus0.A0} <  {bus0.B3, bus0.B2, bus0.B1, bus0.B0});
  assign bus0.A_eq_B = force_en ? force_val[0] :
    ({bus0.A3, bus0.A2, bus0.A1, bus0.A0} == {bus0.B3, bus0.B2, bus0.B1, bus0.B0});

  cmp_operand_sequencer #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  cmp_operand_sequencer #(.SETTLE_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  // Observation word, with bit ranges as follows:
  //   [13:10] A3..A0
  //   [9:6]   B3..B0
  //   [5]     busy
  //   [4]     done
  //   [3:0]   {gt, lt, eq, err}
  logic [13:0] obs1, obs0, obs;
  assign obs1 = {bus1.A3, bus1.A2, bus1.A1, bus1.A0, bus1.B3, bus1.B2, bus1.B1, bus1.B0,
                 bus1.busy, bus1.done, bus1.gt_q, bus1.lt_q, bus1.eq_q, bus1.err};
  assign obs0 = {bus0.A3, bus0.A2, bus0.A1, bus0.A0, bus0.B3, bus0.B2, bus0.B1, bus0.B0,
                 bus0.busy, bus0.done, bus0.gt_q, bus0.lt_q, bus0.eq_q, bus0.err};
  assign obs  = sel ? obs1 : obs0;

  int done_cnt1 = 0;
  int done_cnt0 = 0;
  always @(negedge clk) begin
    if (bus1.done === 1'b1) done_cnt1 += 1;
    if (bus0.done === 1'b1) done_cnt0 += 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] prev_res;
  logic       prev_valid;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       fen;
    logic [2:0] fval;
    logic       noise;
    logic [3:0] exp_res;  // {gt, lt, eq, err}
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Each call advances one clock and then waits until just after the
  // following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_txn(input logic s, input logic [3:0] a, input logic [3:0] b,
                        input logic fen, input logic [2:0] fval, input logic noise,
                        input logic [3:0] exp_res);
    logic [7:0]  bits;
    int unsigned lat;
    int          dc_before;
    int unsigned settle;
    settle    = s ? 1 : 0;
    sel       = s;
    force_en  = fen;
    force_val = fval;
    bits      = {a, b};
    dc_before = s ? done_cnt1 : done_cnt0;
    tb_start  = 1'b1;
    tick();                                  // edge 0: start accepted
    tb_start  = 1'b0;
    check("busy_in_load", obs[5], 1'b1);
    if (prev_valid) check("results_hold_on_start", obs[3:0], prev_res);
    for (int unsigned i = 0; i < 8; i++) begin
      tb_ser   = bits[7 - i];
      tb_start = (noise && i == 3) ? 1'b1 : 1'b0;
      tick();                                // edges 1..8
    end
    check("operands_loaded", obs[13:6], bits);
    check("no_early_done", obs[4], 1'b0);
    tb_ser   = 1'b0;
    tb_start = noise;                        // ignored: edge 9 is SETTLE or CAPTURE
    lat = 0;
    for (int unsigned n = 9; n <= 40; n++) begin
      tick();
      tb_start = 1'b0;
      if (obs[4]) begin
        lat = n;
        break;
      end
    end
    check("done_latency", lat, 9 + settle);
    check("results", obs[3:0], exp_res);
    check("busy_low_at_done", obs[5], 1'b0);
    check("operands_frozen", obs[13:6], bits);
    tick();
    check("done_one_cycle", obs[4], 1'b0);
    tick();
    force_en = 1'b0;
    check("done_count", (s ? done_cnt1 : done_cnt0) - dc_before, 1);
    prev_res   = exp_res;
    prev_valid = 1'b1;
  endtask

  initial begin
    logic [7:0] t1, t2;
    int unsigned first_done, second_done;
    int dc;

    rst        = 1'b1;
    tb_start   = 1'b0;
    tb_ser     = 1'b0;
    force_en   = 1'b0;
    force_val  = 3'b000;
    sel        = 1'b1;
    prev_res   = 4'b0000;
    prev_valid = 1'b0;

    vecs[0]  = '{4'b1011, 4'b0111, 1'b0, 3'b000, 1'b0, 4'b1000};
    vecs[1]  = '{4'b1111, 4'b1111, 1'b0, 3'b000, 1'b0, 4'b0010};
    vecs[2]  = '{4'b0101, 4'b1110, 1'b0, 3'b000, 1'b0, 4'b0100};
    vecs[3]  = '{4'b0000, 4'b0000, 1'b0, 3'b000, 1'b0, 4'b0010};
    vecs[4]  = '{4'b1000, 4'b0111, 1'b0, 3'b000, 1'b0, 4'b1000};
    vecs[5]  = '{4'b0000, 4'b1111, 1'b0, 3'b000, 1'b0, 4'b0100};
    vecs[6]  = '{4'b0110, 4'b0111, 1'b0, 3'b000, 1'b1, 4'b0100};
    vecs[7]  = '{4'b1100, 4'b0011, 1'b1, 3'b101, 1'b0, 4'b1011};
    vecs[8]  = '{4'b0011, 4'b0011, 1'b1, 3'b000, 1'b0, 4'b0001};
    vecs[9]  = '{4'b1010, 4'b0101, 1'b1, 3'b111, 1'b0, 4'b1111};
    vecs[10] = '{4'b1001, 4'b1001, 1'b0, 3'b000, 1'b0, 4'b0010};
    vecs[11] = '{4'b0111, 4'b1000, 1'b0, 3'b000, 1'b1, 4'b0100};

    @(negedge clk);
    #1;
    check("reset_outputs_dut1", obs1, 14'h0);
    check("reset_outputs_dut0", obs0, 14'h0);
    tick();
    rst = 1'b0;
    tick();
    check("idle_after_reset", obs1, 14'h0);
    prev_res   = 4'b0000;
    prev_valid = 1'b1;

    // Main table on the SETTLE_CYCLES=1 instance
    for (int unsigned k = 0; k < 12; k++)
      do_txn(1'b1, vecs[k].a, vecs[k].b, vecs[k].fen, vecs[k].fval, vecs[k].noise,
             vecs[k].exp_res);

    // Zero-settle instance: done one cycle earlier
    do_txn(1'b0, vecs[0].a, vecs[0].b, 1'b0, 3'b000, 1'b0, vecs[0].exp_res);
    do_txn(1'b0, vecs[2].a, vecs[2].b, 1'b0, 3'b000, 1'b1, vecs[2].exp_res);

    // Back-to-back with start held high through the first CAPTURE
    sel = 1'b1;
    t1  = 8'b1011_0111;
    t2  = 8'b0101_1110;
    dc  = done_cnt1;
    first_done  = 0;
    second_done = 0;
    for (int unsigned e = 0; e <= 30; e++) begin
      if (e >= 1 && e <= 8)        tb_ser = t1[8 - e];
      else if (e >= 12 && e <= 19) tb_ser = t2[19 - e];
      else                         tb_ser = 1'b0;
      tb_start = (e <= 11);
      tick();
      if (bus1.done) begin
        if (first_done == 0) begin
          first_done = e;
          check("b2b_first_results", obs1[3:0], 4'b1000);
        end else if (second_done == 0) begin
          second_done = e;
          check("b2b_second_results", obs1[3:0], 4'b0100);
        end
      end
    end
    tb_start = 1'b0;
    check("b2b_first_done_edge", first_done, 10);
    check("b2b_interval", second_done - first_done, 11);
    check("b2b_done_count", done_cnt1 - dc, 2);
    prev_valid = 1'b0;
    for (int unsigned i = 0; i < 20; i++) tick();

    // Asynchronous reset after three LOAD bits
    sel      = 1'b1;
    tb_start = 1'b1;
    tick();
    tb_start = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      tb_ser = 1'b1;
      tick();
    end
    check("pre_reset_state_nonzero", (obs1 != 14'h0), 1'b1);
    #1 rst = 1'b1;
    #1;
    check("async_reset_dut1", obs1, 14'h0);
    check("async_reset_dut0", obs0, 14'h0);
    dc = done_cnt1;
    tick();
    rst = 1'b0;
    for (int unsigned i = 0; i < 12; i++) tick();
    check("no_done_after_abort", done_cnt1 - dc, 0);
    check("idle_after_abort", obs1, 14'h0);
    prev_res   = 4'b0000;
    prev_valid = 1'b1;
    tb_ser     = 1'b0;

    // Post-reset transaction still works
    do_txn(1'b1, 4'b0100, 4'b0010, 1'b0, 3'b000, 1'b0, 4'b1000);

`ifdef CMP_SEQ_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    prev_res   = 4'b0000;
    prev_valid = 1'b1;
    check("stats_reset", {bus0.gt_cnt, bus0.lt_cnt, bus0.eq_cnt}, 24'h0);
    for (int unsigned k = 0; k < 3; k++)
      do_txn(1'b0, 4'b1001, 4'b0011, 1'b0, 3'b000, 1'b0, 4'b1000);
    check("gt_cnt_3", bus0.gt_cnt, 8'd3);
    check("lt_cnt_0", bus0.lt_cnt, 8'd0);
    for (int unsigned k = 0; k < 300; k++)
      do_txn(1'b0, 4'b0110, 4'b0110, 1'b0, 3'b000, 1'b0, 4'b0010);
    check("eq_cnt_saturated", bus0.eq_cnt, 8'd255);
    check("gt_cnt_kept", bus0.gt_cnt, 8'd3);
    check("lt_cnt_kept", bus0.lt_cnt, 8'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
